// File: rtl/glyph_blitter.sv
// Streams one glyph bitmap as per-pixel plot commands with integer scaling,
// optional transparency and clipping at the visible screen edge.
module glyph_blitter #(
  parameter int unsigned GLYPH_W  = 8,
  parameter int unsigned GLYPH_H  = 16,
  parameter int unsigned SCALE    = 1,
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned COLOUR_W = 3,
  parameter int unsigned X_MAX    = 159,
  parameter int unsigned Y_MAX    = 119
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [6:0]                 req_char,
  input  logic [X_W-1:0]             req_x,
  input  logic [Y_W-1:0]             req_y,
  input  logic [COLOUR_W-1:0]        req_fg,
  input  logic [COLOUR_W-1:0]        req_bg,
  input  logic                       req_transp,
  output logic [6:0]                 glyph_code,
  input  logic [GLYPH_W*GLYPH_H-1:0] glyph_bits,
  output logic [X_W-1:0]             plot_x,
  output logic [Y_W-1:0]             plot_y,
  output logic [COLOUR_W-1:0]        plot_colour,
  output logic                       plot,
  input  logic                       plot_ready,
  output logic                       done
);

  localparam int unsigned NBits = GLYPH_W * GLYPH_H;
  localparam int unsigned IW    = $clog2(NBits);
  localparam int unsigned GCW   = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int unsigned GRW   = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int unsigned SW    = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [X_W:0] XLim = (X_W + 1)'(X_MAX);
  localparam logic [Y_W:0] YLim = (Y_W + 1)'(Y_MAX);

  typedef enum logic [1:0] {StIdle, StLoad, StDraw, StDone} state_e;

  state_e                state_q, state_d;
  logic [6:0]            char_q, char_d;
  logic [X_W-1:0]        x0_q, x0_d;
  logic [Y_W-1:0]        y0_q, y0_d;
  logic [COLOUR_W-1:0]   fg_q, fg_d, bg_q, bg_d;
  logic                  transp_q, transp_d;
  logic [NBits-1:0]      bits_q, bits_d;
  logic [GCW-1:0]        gcol_q, gcol_d;
  logic [GRW-1:0]        grow_q, grow_d;
  logic [SW-1:0]         scol_q, scol_d, srow_q, srow_d;
  logic [X_W:0]          col_q, col_d;
  logic [Y_W:0]          row_q, row_d;
  logic                  last_q, last_d;
  logic                  plot_q, plot_d;
  logic [X_W-1:0]        px_q, px_d;
  logic [Y_W-1:0]        py_q, py_d;
  logic [COLOUR_W-1:0]   pc_q, pc_d;

  logic [NBits-1:0] bits_src;
  logic [IW-1:0]    bit_idx;
  logic             pix_bit, slot_plot, load_slot;
  logic             scol_end, srow_end, col_end, row_end;
  logic [X_W:0]     sum_x;
  logic [Y_W:0]     sum_y;

  // The LOAD cycle evaluates slot 0 straight from the lookup so DRAW starts presenting at once.
  always_comb begin
    bits_src  = (state_q == StLoad) ? glyph_bits : bits_q;
    bit_idx   = IW'(NBits - 1) - (IW'(grow_q) * IW'(GLYPH_W) + IW'(gcol_q));
    pix_bit   = bits_src[bit_idx];
    sum_x     = {1'b0, x0_q} + col_q;
    sum_y     = {1'b0, y0_q} + row_q;
    slot_plot = !(transp_q && !pix_bit) && (sum_x <= XLim) && (sum_y <= YLim);
    scol_end  = (scol_q == SW'(SCALE - 1));
    srow_end  = (srow_q == SW'(SCALE - 1));
    col_end   = scol_end && (gcol_q == GCW'(GLYPH_W - 1));
    row_end   = srow_end && (grow_q == GRW'(GLYPH_H - 1));
  end

  always_comb begin
    state_d   = state_q;
    char_d    = char_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    fg_d      = fg_q;
    bg_d      = bg_q;
    transp_d  = transp_q;
    bits_d    = bits_q;
    gcol_d    = gcol_q;
    grow_d    = grow_q;
    scol_d    = scol_q;
    srow_d    = srow_q;
    col_d     = col_q;
    row_d     = row_q;
    last_d    = last_q;
    plot_d    = plot_q;
    px_d      = px_q;
    py_d      = py_q;
    pc_d      = pc_q;
    load_slot = 1'b0;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          char_d   = req_char;
          x0_d     = req_x;
          y0_d     = req_y;
          fg_d     = req_fg;
          bg_d     = req_bg;
          transp_d = req_transp;
          gcol_d   = '0;
          grow_d   = '0;
          scol_d   = '0;
          srow_d   = '0;
          col_d    = '0;
          row_d    = '0;
          last_d   = 1'b0;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        bits_d    = glyph_bits;
        load_slot = 1'b1;
        state_d   = StDraw;
      end
      StDraw: begin
        if (plot_ready) begin
          if (last_q) begin
            plot_d  = 1'b0;
            state_d = StDone;
          end else begin
            load_slot = 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (load_slot) begin
      plot_d = slot_plot;
      px_d   = sum_x[X_W-1:0];
      py_d   = sum_y[Y_W-1:0];
      pc_d   = pix_bit ? fg_q : bg_q;
      last_d = col_end && row_end;
      if (col_end) begin
        col_d  = '0;
        gcol_d = '0;
        scol_d = '0;
        row_d  = row_q + 1'b1;
        if (srow_end) begin
          srow_d = '0;
          grow_d = grow_q + 1'b1;
        end else begin
          srow_d = srow_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
        if (scol_end) begin
          scol_d = '0;
          gcol_d = gcol_q + 1'b1;
        end else begin
          scol_d = scol_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      char_q   <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      fg_q     <= '0;
      bg_q     <= '0;
      transp_q <= 1'b0;
      bits_q   <= '0;
      gcol_q   <= '0;
      grow_q   <= '0;
      scol_q   <= '0;
      srow_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      last_q   <= 1'b0;
      plot_q   <= 1'b0;
      px_q     <= '0;
      py_q     <= '0;
      pc_q     <= '0;
    end else begin
      state_q  <= state_d;
      char_q   <= char_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      fg_q     <= fg_d;
      bg_q     <= bg_d;
      transp_q <= transp_d;
      bits_q   <= bits_d;
      gcol_q   <= gcol_d;
      grow_q   <= grow_d;
      scol_q   <= scol_d;
      srow_q   <= srow_d;
      col_q    <= col_d;
      row_q    <= row_d;
      last_q   <= last_d;
      plot_q   <= plot_d;
      px_q     <= px_d;
      py_q     <= py_d;
      pc_q     <= pc_d;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign done        = (state_q == StDone);
  assign glyph_code  = char_q;
  assign plot        = plot_q;
  assign plot_x      = px_q;
  assign plot_y      = py_q;
  assign plot_colour = pc_q;

endmodule

// File: tb/tb_glyph_blitter.sv
// Bench for glyph_blitter: a SCALE=1 and a SCALE=2 instance checked against a pixel-list model.
module tb_glyph_blitter;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  logic va, vb, pra, prb;
  logic [6:0] rc;
  logic [7:0] rx;
  logic [6:0] ry;
  logic [2:0] rfg, rbg;
  logic       rtr;

  logic         rdy_a, pl_a, dn_a, rdy_b, pl_b, dn_b;
  logic [6:0]   gc_a, gc_b, py_a, py_b;
  logic [127:0] gb_a, gb_b;
  logic [7:0]   px_a, px_b;
  logic [2:0]   pc_a, pc_b;

  int   n_vec = 0;
  int   n_err = 0;
  bit   sel = 1'b0;
  pix_t got_q[$];

  logic       s_rdy, s_pl, s_dn;
  logic [7:0] s_px;
  logic [6:0] s_py;
  logic [2:0] s_pc;

  function automatic logic [127:0] glyph_of(input logic [6:0] c);
    logic [127:0] g;
    case (c)
      7'd32:   g = '0;
      7'd33:   g = 128'h00383838_38381010_00101000_00000000;
      7'd65:   g = 128'h00102844_8282FE82_82828200_00000000;
      7'd72:   g = 128'h00828282_82FE8282_82828200_00000000;
      default: begin
        for (int i = 0; i < 16; i++) g[127 - 8 * i -: 8] = 8'((int'(c) * 29 + i * 53) ^ (i * 7));
      end
    endcase
    return g;
  endfunction

  assign gb_a = glyph_of(gc_a);
  assign gb_b = glyph_of(gc_b);

  glyph_blitter u_dut_a (
    .clock(clock), .resetn(resetn), .req_valid(va), .req_ready(rdy_a), .req_char(rc),
    .req_x(rx), .req_y(ry), .req_fg(rfg), .req_bg(rbg), .req_transp(rtr),
    .glyph_code(gc_a), .glyph_bits(gb_a), .plot_x(px_a), .plot_y(py_a),
    .plot_colour(pc_a), .plot(pl_a), .plot_ready(pra), .done(dn_a)
  );

  glyph_blitter #(.SCALE(2)) u_dut_b (
    .clock(clock), .resetn(resetn), .req_valid(vb), .req_ready(rdy_b), .req_char(rc),
    .req_x(rx), .req_y(ry), .req_fg(rfg), .req_bg(rbg), .req_transp(rtr),
    .glyph_code(gc_b), .glyph_bits(gb_b), .plot_x(px_b), .plot_y(py_b),
    .plot_colour(pc_b), .plot(pl_b), .plot_ready(prb), .done(dn_b)
  );

  always_comb begin
    s_rdy = sel ? rdy_b : rdy_a;
    s_pl  = sel ? pl_b : pl_a;
    s_dn  = sel ? dn_b : dn_a;
    s_px  = sel ? px_b : px_a;
    s_py  = sel ? py_b : py_a;
    s_pc  = sel ? pc_b : pc_a;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Draws one glyph on instance b (0: SCALE=1, 1: SCALE=2); optional stall or mid-draw reset.
  task automatic run(input bit b, input logic [6:0] c, input logic [7:0] x, input logic [6:0] y,
                     input logic [2:0] fg, input logic [2:0] bg, input logic tr,
                     input int stall_at, input int stall_len, input int rst_at);
    pix_t         exp_q[$];
    logic [127:0] g;
    logic [18:0]  snap;
    logic         bitv, p;
    int           s, slots, first_slot, first_cyc, done_cyc, k, n;
    s          = b ? 2 : 1;
    slots      = 128 * s * s;
    first_slot = -1;
    first_cyc  = -1;
    done_cyc   = -1;
    snap       = '0;
    g          = glyph_of(c);
    for (int r = 0; r < 16 * s; r++) begin
      for (int q = 0; q < 8 * s; q++) begin
        bitv = g[127 - ((r / s) * 8 + q / s)];
        if (int'(x) + q <= 159 && int'(y) + r <= 119 && (bitv || !tr)) begin
          exp_q.push_back(pix_t'{8'(int'(x) + q), 7'(int'(y) + r), bitv ? fg : bg});
          if (first_slot < 0) first_slot = r * 8 * s + q;
        end
      end
    end
    got_q.delete();
    sel = b;
    @(negedge clock);
    chk("req_ready_idle", 32'(s_rdy), 32'd1);
    rc = c; rx = x; ry = y; rfg = fg; rbg = bg; rtr = tr;
    if (b) vb = 1'b1; else va = 1'b1;
    @(negedge clock);
    va = 1'b0;
    vb = 1'b0;
    k  = 1;
    chk("req_ready_busy", 32'(s_rdy), 32'd0);
    while (k <= slots + stall_len + 8) begin
      p = !(k >= stall_at && k < stall_at + stall_len);
      if (b) prb = p; else pra = p;
      if (k == rst_at) begin
        resetn = 1'b0;
        #1;
        chk("rst_plot", 32'(s_pl), 32'd0);
        chk("rst_ready", 32'(s_rdy), 32'd1);
        chk("rst_plot_x", 32'(s_px), 32'd0);
        chk("rst_done", 32'(s_dn), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        return;
      end
      if (k == stall_at) snap = {s_pl, s_px, s_py, s_pc};
      if (k > stall_at && k <= stall_at + stall_len)
        chk("stall_hold", 32'({s_pl, s_px, s_py, s_pc}), 32'(snap));
      if (s_pl && p) begin
        got_q.push_back(pix_t'{s_px, s_py, s_pc});
        if (first_cyc < 0) first_cyc = k;
      end
      if (s_dn) begin
        done_cyc = k;
        break;
      end
      @(negedge clock);
      k++;
    end
    chk("done_cycle", 32'(done_cyc), 32'(slots + 2 + stall_len));
    if (stall_len == 0 && first_slot >= 0)
      chk("first_plot_cycle", 32'(first_cyc), 32'(first_slot + 2));
    chk("plot_count", 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("pixel", 32'(got_q[i]), 32'(exp_q[i]));
      if (got_q[i] !== exp_q[i]) break;
    end
    @(negedge clock);
    chk("done_pulse_end", 32'(s_dn), 32'd0);
    chk("ready_after", 32'(s_rdy), 32'd1);
  endtask

  function automatic pix_t got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : '0;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    va = 1'b0; vb = 1'b0; pra = 1'b1; prb = 1'b1;
    rc = '0; rx = '0; ry = '0; rfg = '0; rbg = '0; rtr = 1'b0;
    #12;
    chk("reset_ready", 32'(rdy_a), 32'd1);
    chk("reset_plot", 32'(pl_a), 32'd0);
    chk("reset_done", 32'(dn_a), 32'd0);
    chk("reset_xyc", 32'({px_a, py_a, pc_a}), 32'd0);
    chk("reset_code", 32'(gc_a), 32'd0);
    chk("reset_b", 32'({rdy_b, pl_b, dn_b}), 32'b100);
    @(negedge clock);
    resetn = 1'b1;

    run(1'b0, 7'd65, 8'd10, 7'd20, 3'd7, 3'd1, 1'b0, 0, 0, -1);
    chk("A_first_pixel", 32'(got_at(0)), 32'(pix_t'{8'd10, 7'd20, 3'd1}));
    chk("A_13_21", 32'(got_at(11)), 32'(pix_t'{8'd13, 7'd21, 3'd7}));

    run(1'b0, 7'd32, 8'd10, 7'd20, 3'd7, 3'd1, 1'b1, 0, 0, -1);

    run(1'b1, 7'd33, 8'd0, 7'd0, 3'd5, 3'd2, 1'b0, 0, 0, -1);
    chk("S2_4_2", 32'(got_at(2 * 16 + 4)), 32'(pix_t'{8'd4, 7'd2, 3'd5}));
    chk("S2_5_3", 32'(got_at(3 * 16 + 5)), 32'(pix_t'{8'd5, 7'd3, 3'd5}));
    chk("S2_0_0", 32'(got_at(0)), 32'(pix_t'{8'd0, 7'd0, 3'd2}));

    run(1'b0, 7'd65, 8'd30, 7'd40, 3'd3, 3'd4, 1'b0, 43, 5, -1);
    run(1'b0, 7'd72, 8'd156, 7'd110, 3'd6, 3'd0, 1'b0, 0, 0, -1);

    run(1'b0, 7'd65, 8'd10, 7'd20, 3'd7, 3'd1, 1'b0, 0, 0, 50);
    run(1'b0, 7'd65, 8'd10, 7'd20, 3'd7, 3'd1, 1'b0, 0, 0, -1);

    for (int t = 0; t < 5; t++) begin
      run(1'b0, 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)),
          7'($urandom_range(0, 127)), 3'($urandom), 3'($urandom), 1'($urandom),
          (t % 2 == 1) ? int'($urandom_range(3, 120)) : 0,
          (t % 2 == 1) ? int'($urandom_range(1, 6)) : 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
